// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises the IF (fetch) and MEM (load/store) stages onto one
// single-ported memory with a req/ack bus of variable latency. It holds the pipeline
// stalled until every access needed this pipeline cycle has completed, and it keeps
// a saturating count of stalled cycles.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_read_i,
  input  logic              dm_write_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic { IDLE, BUSY } state_t;
  typedef enum logic { SRV_D, SRV_I } srv_t;

  state_t state;
  srv_t   srv;
  logic   i_done;
  logic   d_done;
  logic   dm_req;

  // A store and a load asserted together are treated as a store.
  assign dm_req  = dm_read_i | dm_write_i;

  // Hold the whole pipeline until each active requester has completed its access.
  assign stall_o = (if_req_i & ~i_done) | (dm_req & ~d_done);

  // Issue/complete FSM; bus outputs and read-data holding registers are registered here.
  // NOTE: every register, including the data holding registers, is reset so the bus
  // and read ports come out of reset at a known 0 rather than X.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      srv         <= SRV_D;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; a later assignment in
      // this block (done set on ack) deliberately overrides the earlier clear.
      if (!stall_o) begin
        // The pipeline advances this edge, so the next pipeline cycle starts fresh.
        i_done <= 1'b0;
        d_done <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            // Data goes first: it belongs to the older instruction.
            if (dm_req && !d_done) begin
              mem_addr_o  <= dm_addr_i;
              mem_wdata_o <= dm_wdata_i;
              mem_we_o    <= dm_write_i;
              mem_req_o   <= 1'b1;
              srv         <= SRV_D;
              state       <= BUSY;
            end else if (if_req_i && !i_done) begin
              mem_addr_o  <= if_addr_i;
              mem_wdata_o <= '0;
              mem_we_o    <= 1'b0;
              mem_req_o   <= 1'b1;
              srv         <= SRV_I;
              state       <= BUSY;
            end
          end
        end
        BUSY: begin
          // Address, data and direction stay frozen until the memory acknowledges.
          if (mem_ack_i) begin
            if (!mem_we_o) begin
              if (srv == SRV_I) if_rdata_o <= mem_rdata_i;
              else              dm_rdata_o <= mem_rdata_i;
            end
            if (srv == SRV_I) i_done <= 1'b1;
            else              d_done <= 1'b1;
            mem_req_o <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of cycles spent with the pipeline stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps with a transaction scoreboard. Expected
// memory transactions (and the read data they should deliver) are queued when the
// stimulus is driven and are popped when the DUT raises a memory request.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        dm_read_i;
  logic        dm_write_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o, stall_cnt_o;
  logic        stall_o, mem_req_o, mem_we_o;

  logic [31:0] if_rdata4, dm_rdata4, mem_addr4, mem_wdata4;
  logic [3:0]  stall_cnt4;
  logic        stall4, mem_req4, mem_we4;

  mem_port_arbiter u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .dm_read_i(dm_read_i), .dm_write_i(dm_write_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_cnt_o(stall_cnt_o)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  mem_port_arbiter #(.CNT_W(4)) u_dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata4),
    .dm_read_i(dm_read_i), .dm_write_i(dm_write_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata4), .stall_o(stall4),
    .mem_req_o(mem_req4), .mem_we_o(mem_we4), .mem_addr_o(mem_addr4),
    .mem_wdata_o(mem_wdata4), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_cnt_o(stall_cnt4)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        is_i;
    logic [31:0] rdata;   // value the holding register must show after completion
  } txn_t;

  txn_t sb[$];
  txn_t cur;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   chk_cnt  = 0;
  bit   in_txn   = 1'b0;
  bit   rd_pend  = 1'b0;
  bit   spur_ack = 1'b0;
  int   wait_cfg = 0;
  int   wait_cnt = 0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h00500093;
      32'h14:  return 32'h00100113;
      32'h80:  return 32'hDEADBEEF;
      default: return 32'hC0DE0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then act as the memory and scoreboard monitor at posedge+1.
  task automatic cycle();
    @(posedge clk_i);
    #1;
    if (rd_pend) begin
      rd_pend = 1'b0;
      if (cur.is_i) check("sb_if_rdata", if_rdata_o, cur.rdata);
      else          check("sb_dm_rdata", dm_rdata_o, cur.rdata);
    end
    if (mem_ack_i) begin
      mem_ack_i = 1'b0;
    end else if (spur_ack) begin
      spur_ack    = 1'b0;
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'hBAD0BAD0;
    end else if (mem_req_o) begin
      if (!in_txn) begin
        in_txn   = 1'b1;
        wait_cnt = 0;
        if (sb.size() == 0) begin
          check("sb_unexpected_req", 32'(mem_req_o), 0);
          cur = '0;
        end else begin
          cur = sb.pop_front();
        end
      end
      check("sb_mem_addr", mem_addr_o, cur.addr);
      check("sb_mem_we", 32'(mem_we_o), 32'(cur.we));
      if (cur.we) check("sb_mem_wdata", mem_wdata_o, cur.wdata);
      if (wait_cnt == wait_cfg) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_model(mem_addr_o);
        in_txn      = 1'b0;
        rd_pend     = 1'b1;
      end else begin
        wait_cnt++;
      end
    end
  endtask

  task automatic apply_reset();
    rst_i     = 1'b1;
    mem_ack_i = 1'b0;
    spur_ack  = 1'b0;
    in_txn    = 1'b0;
    rd_pend   = 1'b0;
    cycle();
    rst_i     = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
    dm_read_i = 1'b0; dm_write_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    #12;
    // Reset state
    check("rst_mem_req", 32'(mem_req_o), 0);
    check("rst_mem_we", 32'(mem_we_o), 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_wdata", mem_wdata_o, 0);
    check("rst_if_rdata", if_rdata_o, 0);
    check("rst_dm_rdata", dm_rdata_o, 0);
    check("rst_stall", 32'(stall_o), 0);
    check("rst_cnt", stall_cnt_o, 0);
    check("rst_dut4", 32'(|{if_rdata4, dm_rdata4, stall4, mem_req4, mem_we4,
                            mem_addr4, mem_wdata4, stall_cnt4}), 0);
    cycle();
    rst_i = 1'b0; start_i = 1'b1;

    // Single fetch, zero-wait memory
    if_req_i = 1'b1; if_addr_i = 32'h10;
    sb.push_back('{addr: 32'h10, we: 1'b0, wdata: 32'h0, is_i: 1'b1, rdata: 32'h00500093});
    #1;
    check("t1_stall_n", 32'(stall_o), 1);
    check("t1_req_n", 32'(mem_req_o), 0);
    cycle();
    check("t1_req_n1", 32'(mem_req_o), 1);
    check("t1_stall_n1", 32'(stall_o), 1);
    cycle();
    check("t1_stall_n2", 32'(stall_o), 0);
    check("t1_req_n2", 32'(mem_req_o), 0);
    check("t1_cnt", stall_cnt_o, 2);
    if_req_i = 1'b0;
    cycle();

    // Simultaneous load and fetch: data first, four stalled cycles
    dm_read_i = 1'b1; dm_addr_i = 32'h80; if_req_i = 1'b1; if_addr_i = 32'h14;
    sb.push_back('{addr: 32'h80, we: 1'b0, wdata: 32'h0, is_i: 1'b0, rdata: 32'hDEADBEEF});
    sb.push_back('{addr: 32'h14, we: 1'b0, wdata: 32'h0, is_i: 1'b1, rdata: 32'h00100113});
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("t2_stall_%0d", k), 32'(stall_o), 1);
      cycle();
    end
    check("t2_stall_end", 32'(stall_o), 0);
    check("t2_dm_rdata", dm_rdata_o, 32'hDEADBEEF);
    check("t2_if_rdata", if_rdata_o, 32'h00100113);
    check("t2_cnt", stall_cnt_o, 6);
    dm_read_i = 1'b0; if_req_i = 1'b0;
    cycle();

    // Store with a 3-wait memory: four BUSY cycles, load data untouched
    wait_cfg = 3;
    dm_write_i = 1'b1; dm_addr_i = 32'h40; dm_wdata_i = 32'h12345678;
    sb.push_back('{addr: 32'h40, we: 1'b1, wdata: 32'h12345678, is_i: 1'b0, rdata: 32'hDEADBEEF});
    for (int k = 0; k < 5; k++) begin
      #1 check($sformatf("t3_stall_%0d", k), 32'(stall_o), 1);
      cycle();
    end
    check("t3_stall_end", 32'(stall_o), 0);
    check("t3_cnt", stall_cnt_o, 11);
    dm_write_i = 1'b0;
    wait_cfg = 0;
    cycle();

    // start_i low: no issue, stall held, then the fetch goes out one cycle after start
    apply_reset();
    start_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h20;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("t4_req_%0d", k), 32'(mem_req_o), 0);
      check($sformatf("t4_stall_%0d", k), 32'(stall_o), 1);
      cycle();
    end
    check("t4_cnt5", stall_cnt_o, 5);
    start_i = 1'b1;
    sb.push_back('{addr: 32'h20, we: 1'b0, wdata: 32'h0, is_i: 1'b1, rdata: 32'hC0DE0020});
    cycle();
    check("t4_req_issue", 32'(mem_req_o), 1);
    cycle();
    #1 check("t4_stall_end", 32'(stall_o), 0);
    check("t4_cnt7", stall_cnt_o, 7);
    if_req_i = 1'b0;
    cycle();

    // Reset in the middle of a long access, then a late ack
    wait_cfg = 5;
    dm_read_i = 1'b1; dm_addr_i = 32'h90;
    sb.push_back('{addr: 32'h90, we: 1'b0, wdata: 32'h0, is_i: 1'b0, rdata: 32'h0});
    cycle();
    check("t5_req_busy0", 32'(mem_req_o), 1);
    cycle();
    check("t5_req_busy1", 32'(mem_req_o), 1);
    rst_i = 1'b1; dm_read_i = 1'b0; in_txn = 1'b0; rd_pend = 1'b0;
    #1;
    check("t5_rst_req", 32'(mem_req_o), 0);
    check("t5_rst_addr", mem_addr_o, 0);
    check("t5_rst_stall", 32'(stall_o), 0);
    check("t5_rst_cnt", stall_cnt_o, 0);
    check("t5_rst_if_rdata", if_rdata_o, 0);
    cycle();
    rst_i = 1'b0; wait_cfg = 0; spur_ack = 1'b1;
    cycle();
    cycle();
    check("t5_late_ack_req", 32'(mem_req_o), 0);
    check("t5_late_ack_dm", dm_rdata_o, 0);
    check("t5_late_ack_stall", 32'(stall_o), 0);
    if_req_i = 1'b1; if_addr_i = 32'h10;
    sb.push_back('{addr: 32'h10, we: 1'b0, wdata: 32'h0, is_i: 1'b1, rdata: 32'h00500093});
    cycle();
    check("t5_next_req", 32'(mem_req_o), 1);
    cycle();
    #1 check("t5_next_stall", 32'(stall_o), 0);
    if_req_i = 1'b0;
    check("t5_next_cnt", stall_cnt_o, 2);
    cycle();

    // Spurious ack while idle changes nothing
    spur_ack = 1'b1;
    cycle();
    cycle();
    check("t6_spur_req", 32'(mem_req_o), 0);
    check("t6_spur_stall", 32'(stall_o), 0);
    check("t6_spur_if_rdata", if_rdata_o, 32'h00500093);
    check("t6_spur_dm_rdata", dm_rdata_o, 0);
    check("t6_spur_cnt", stall_cnt_o, 2);

    // Counter saturation over 20 stalled cycles
    apply_reset();
    start_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h30;
    for (int k = 0; k < 20; k++) cycle();
    check("t7_cnt4_sat", 32'(stall_cnt4), 15);
    check("t7_cnt32", stall_cnt_o, 20);
    check("t7_req", 32'(mem_req_o), 0);
    if_req_i = 1'b0; start_i = 1'b1;
    cycle();

    check("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store) of the 5-stage pipeline. It serialises the two requesters onto a req/ack memory bus of variable latency. It returns read data in holding registers and drives one pipeline-wide stall until every access for the current pipeline cycle has completed. It also keeps a saturating stall-cycle performance counter.

Parameters:
ADDR_W, 32, address width of requesters and memory bus
DATA_W, 32, data width
CNT_W, 32, width of stall-cycle counter

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
start_i  input  1  run enable; when low, no new memory transaction is issued
if_req_i  input  1  IF stage wants an instruction this pipeline cycle
if_addr_i  input  ADDR_W  fetch address (PC)
if_rdata_o  output  DATA_W  fetched instruction (registered)
dm_read_i  input  1  MEM stage load
dm_write_i  input  1  MEM stage store
dm_addr_i  input  ADDR_W  data address (EX/MEM ALU result)
dm_wdata_i  input  DATA_W  store data
dm_rdata_o  output  DATA_W  load data (registered)
stall_o  output  1  freeze PC and all pipeline registers
mem_req_o  output  1  memory request (registered)
mem_we_o  output  1  1 = write, 0 = read
mem_addr_o  output  ADDR_W  memory address
mem_wdata_o  output  DATA_W  memory write data
mem_ack_i  input  1  one-cycle completion pulse; rdata valid with it
mem_rdata_i  input  DATA_W  memory read data
stall_cnt_o  output  CNT_W  number of cycles with stall_o=1, saturating

Behaviour:
- Reset values: all outputs 0; state IDLE; i_done=d_done=0.
- dm_req = dm_read_i | dm_write_i. If both dm_read_i and dm_write_i are high, the access is a write.
- stall_o is combinational: (if_req_i & ~i_done) | (dm_req & ~d_done).
- FSM states are IDLE and BUSY, plus a served-requester register srv (D or I).
- IDLE, start_i=1:
  - If dm_req & ~d_done: latch dm address, data and we; srv=D; go to BUSY.
  - Else if if_req_i & ~i_done: latch if_addr_i, we=0; srv=I; go to BUSY.
  - Data has fixed priority over instructions, because the older instruction goes first.
- IDLE, start_i=0: stay in IDLE. stall_o still follows the formula.
- BUSY:
  - mem_req_o=1. mem_addr_o, mem_we_o and mem_wdata_o are held stable from the latch until ack.
  - On mem_ack_i: for a read, capture mem_rdata_i into if_rdata_o or dm_rdata_o per srv. Set the matching done flag, drop mem_req_o, and return to IDLE.
  - mem_ack_i may arrive in the first BUSY cycle.
  - A store does not update dm_rdata_o.
- mem_ack_i outside BUSY is ignored.
- On any clock edge where stall_o=0, i_done and d_done clear, because the pipeline advances. The rdata registers hold their value until overwritten.
- Requester inputs must stay stable while stall_o=1. Changes made during BUSY are not observed until the next issue.
- Latency:
  - Single access: request in cycle N, mem_req_o in N+1; with ack in N+1, stall_o=0 in N+2.
  - Both requesters, zero-wait memory: D issued N+1, I issued N+3, stall_o=0 in N+4.
  - Each memory wait cycle adds one cycle.
- Minimum gap between transactions: one IDLE cycle after each ack.
- stall_cnt_o increments on every cycle with stall_o=1 and saturates at all-ones.
- Asserting rst_i mid-transaction immediately clears mem_req_o and the done flags. A late ack after reset is ignored.

Test Plan:
- Single fetch: if_req_i=1, addr 0x10, memory returns 0x00500093 on the first BUSY cycle -> mem_req_o high 1 cycle with addr 0x10 and we=0; stall_o high 2 cycles; if_rdata_o=0x00500093; stall_cnt_o=2.
- Simultaneous load and fetch: dm_read_i at 0x80 (mem 0xDEADBEEF) plus if_req_i at 0x14, zero wait -> data access issued first; stall_o high 4 cycles; dm_rdata_o=0xDEADBEEF and if_rdata_o correct.
- Store with 3-wait memory: dm_write_i, addr 0x40, wdata 0x12345678 -> mem_we_o=1 and addr/wdata stable for all 4 BUSY cycles; dm_rdata_o unchanged; stall released 1 cycle after ack.
- start_i=0 with if_req_i=1 for 5 cycles -> mem_req_o stays 0; stall_o=1; stall_cnt_o=5. Raising start_i then issues the fetch on the next cycle.
- Reset mid-BUSY: assert rst_i while mem_req_o=1, then send a late ack -> all outputs 0 immediately; the ack is ignored; the next request is serviced normally.
- Spurious mem_ack_i in IDLE, and counter saturation with CNT_W=4 over 20 stall cycles -> no state change from the ack; stall_cnt_o=15.
